lpddr2_port_arbiter: RTL and testbench
======================================

# lpddr2_port_arbiter

Two-master Avalon-MM arbiter that shares one LPDDR2 multiport-controller port between a write requester (capture/pattern loader) and a read requester (video scanout prefetch). It sits between the requesters and one `avl_*_N` port of `fpga_lpddr2`, in that port's command clock domain. It locks grants per burst and tracks outstanding reads so that returned data goes to the issuing master. An urgency input lets the scanout path pre-empt round-robin, bounded by a starvation limit.

## Interface
- ADDR_W, 27, Avalon word address width
- DATA_W, 32, data width
- BC_W, 3, burstcount width; legal bursts are 1..4
- MAX_OUTST, 8, read-tracking FIFO depth (outstanding read commands)
- STARVE_LIMIT, 16, maximum consecutive urgent grants to master 1 while master 0 is waiting
- iCLK  in  1  port command clock; all logic is on its rising edge
- iRST_n  in  1  asynchronous active-low reset
- local_init_done  in  1  no grant is issued while low
- m1_urgent  in  1  master 1 FIFO is below its low watermark
- mN_read, mN_write  in  1  request, for N = 0 and 1
- mN_address  in  ADDR_W; mN_writedata  in  DATA_W; mN_burstcount  in  BC_W
- mN_waitrequest_n  out  1  command or beat accepted
- mN_readdata  out  DATA_W  avl_rdata, broadcast
- mN_readdatavalid  out  1  routed valid
- avl_ready  in  1  controller waitrequest_n
- avl_rdata  in  DATA_W; avl_rdata_valid  in  1
- avl_addr  out  ADDR_W; avl_wdata  out  DATA_W; avl_size  out  BC_W
- avl_read_req, avl_write_req, avl_burstbegin  out  1
- err_orphan  out  1  sticky: rdata_valid was seen with the tracking FIFO empty

## Operation
- States: IDLE, GNT0, GNT1. Register last_grant resets to 1, so master 0 wins the first tie.
- IDLE: act only when local_init_done=1 and at least one request is eligible. A read is eligible only if the tracking FIFO is not full.
  - Single eligible master: grant it.
  - Both eligible and m1_urgent=1 and starve_cnt<STARVE_LIMIT: grant master 1.
  - Otherwise: grant !last_grant.
  - On granting, update last_grant. starve_cnt increments on an urgent win over a waiting master 0 and clears on any master-0 grant.
- GNTn: avl_addr, avl_wdata, avl_size, avl_read_req and avl_write_req are combinationally muxed from master n. Burstcount 0 is issued as 1.
  - mn_waitrequest_n = avl_ready. The other master sees waitrequest_n = 0.
  - avl_burstbegin is high on the first write beat and on the read command. It is held until that beat is accepted.
- Write burst: latch burstcount on the first accepted beat. Count accepted beats (valid & avl_ready). After the last beat, go to IDLE.
  - If the master drops write mid-burst, the grant is held, outputs show write=0, and no timeout applies.
- Read: on acceptance, push {owner, burstcount} into the tracking FIFO and go to IDLE.
- Read return: each avl_rdata_valid asserts the readdatavalid of the head owner and decrements the head beat count. The head is popped on its last beat.
- Push and pop in the same cycle are legal. The full check uses the pre-pop count (conservative).
- An avl_rdata_valid arriving with the FIFO empty is dropped and sets err_orphan.
- Requests in GNTn from the non-granted master wait. Nothing is queued.

## Timing
- Reset (async assert, sync deassert handled upstream) sets:
  - state IDLE, last_grant 1, starve_cnt 0, FIFO empty, err_orphan 0
  - all avl_* request outputs 0
  - both waitrequest_n 0, both readdatavalid 0
- Request-to-command latency: 1 cycle. A request seen in IDLE at cycle t appears on avl_* at t+1.
- Each grant costs one idle bubble, so back-to-back single reads reach at most 1 command per 2 cycles.
- Read data: mN_readdatavalid is combinational from avl_rdata_valid, with 0 added latency.
- Reset mid-burst or with reads outstanding: everything clears immediately and in-flight data is discarded. The controller is reset in the same domain.

## Test plan
- Master 0 issues a write burst of 4 with avl_ready stalled 2 cycles on beat 2 → exactly 4 write beats, burstbegin only on beat 1, master 1 waitrequest_n=0 throughout, return to IDLE after beat 4.
- Both masters request single reads continuously, m1_urgent=0 → grants alternate 0,1,0,1 starting with 0. Read data is returned in order with correct readdatavalid routing.
- m1_urgent=1 held while master 0 writes continuously → master 1 wins 16 consecutive grants, master 0 gets the 17th, then the counter restarts.
- Master 1 issues 8 reads of burst 2 with data withheld → 9th read stalls (waitrequest_n=0) while master 0 writes proceed. Releasing 2 beats lets the 9th read issue.
- avl_rdata_valid pulsed with no outstanding reads → err_orphan=1 (sticky), no readdatavalid. iRST_n pulse clears it.
- local_init_done=0 with requests pending → no avl_* activity. Its rise → first command 1 cycle after the next IDLE evaluation.

Source files
------------

// File: rtl/lpddr2_port_arbiter.sv
// Two-master Avalon-MM arbiter for one LPDDR2 controller port: burst-locked grants,
// urgency pre-emption with a starvation bound, and in-order read-return routing.
module lpddr2_port_arbiter #(
    parameter int unsigned ADDR_W       = 27,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned BC_W         = 3,
    parameter int unsigned MAX_OUTST    = 8,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              local_init_done,
    input  logic              m1_urgent,

    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BC_W-1:0]   m0_burstcount,
    output logic              m0_waitrequest_n,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BC_W-1:0]   m1_burstcount,
    output logic              m1_waitrequest_n,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    input  logic              avl_ready,
    input  logic [DATA_W-1:0] avl_rdata,
    input  logic              avl_rdata_valid,
    output logic [ADDR_W-1:0] avl_addr,
    output logic [DATA_W-1:0] avl_wdata,
    output logic [BC_W-1:0]   avl_size,
    output logic              avl_read_req,
    output logic              avl_write_req,
    output logic              avl_burstbegin,
    output logic              err_orphan
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [1:0]      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [SC_W-1:0] starve_q, starve_d;
    logic            gnt_wr_q, gnt_wr_d;
    logic            wr_started_q, wr_started_d;
    logic [BC_W-1:0] wr_len_q, wr_len_d;
    logic [BC_W-1:0] wr_cnt_q, wr_cnt_d;

    logic            fifo_owner_q [MAX_OUTST];
    logic [BC_W-1:0] fifo_len_q   [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] fifo_cnt_q;
    logic [BC_W-1:0]  head_beats_q;
    logic             err_orphan_q;

    logic              fifo_full, fifo_empty;
    logic              m0_elig, m1_elig;
    logic              in_gnt, sel1;
    logic              g_read, g_write;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [BC_W-1:0]   g_bc, g_len;
    logic              wr_accept, rd_accept;
    logic              rv_hit, head_owner, head_last, push, pop;
    logic [BC_W-1:0]   head_len;
    logic              pick, urgent_win;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full check uses the registered count, so a same-cycle pop never frees a slot early.
    assign fifo_full  = (fifo_cnt_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign m0_elig    = m0_write | (m0_read & ~fifo_full);
    assign m1_elig    = m1_write | (m1_read & ~fifo_full);

    assign in_gnt  = (state_q != IDLE);
    assign sel1    = (state_q == GNT1);
    assign g_read  = sel1 ? m1_read       : m0_read;
    assign g_write = sel1 ? m1_write      : m0_write;
    assign g_addr  = sel1 ? m1_address    : m0_address;
    assign g_wdata = sel1 ? m1_writedata  : m0_writedata;
    assign g_bc    = sel1 ? m1_burstcount : m0_burstcount;
    assign g_len   = (g_bc == '0) ? BC_W'(1) : g_bc;

    assign avl_write_req    = in_gnt & gnt_wr_q & g_write;
    assign avl_read_req     = in_gnt & ~gnt_wr_q & g_read;
    assign avl_burstbegin   = avl_read_req | (avl_write_req & ~wr_started_q);
    assign avl_addr         = in_gnt ? g_addr  : '0;
    assign avl_wdata        = in_gnt ? g_wdata : '0;
    assign avl_size         = in_gnt ? g_len   : '0;
    assign m0_waitrequest_n = (state_q == GNT0) & avl_ready;
    assign m1_waitrequest_n = (state_q == GNT1) & avl_ready;

    assign wr_accept = avl_write_req & avl_ready;
    assign rd_accept = avl_read_req & avl_ready;

    assign head_owner       = fifo_owner_q[rd_ptr_q];
    assign head_len         = fifo_len_q[rd_ptr_q];
    assign head_last        = ((head_beats_q + BC_W'(1)) == head_len);
    assign rv_hit           = avl_rdata_valid & ~fifo_empty;
    assign push             = rd_accept;
    assign pop              = rv_hit & head_last;
    assign m0_readdata      = avl_rdata;
    assign m1_readdata      = avl_rdata;
    assign m0_readdatavalid = rv_hit & ~head_owner;
    assign m1_readdatavalid = rv_hit & head_owner;
    assign err_orphan       = err_orphan_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        starve_d     = starve_q;
        gnt_wr_d     = gnt_wr_q;
        wr_started_d = wr_started_q;
        wr_len_d     = wr_len_q;
        wr_cnt_d     = wr_cnt_q;
        pick         = 1'b0;
        urgent_win   = 1'b0;
        case (state_q)
            IDLE: begin
                if (local_init_done && (m0_elig || m1_elig)) begin
                    if (m0_elig && !m1_elig) begin
                        pick = 1'b0;
                    end else if (!m0_elig && m1_elig) begin
                        pick = 1'b1;
                    end else if (m1_urgent && (starve_q < SC_W'(STARVE_LIMIT))) begin
                        pick       = 1'b1;
                        urgent_win = 1'b1;
                    end else begin
                        pick = ~last_grant_q;
                    end
                    state_d      = pick ? GNT1 : GNT0;
                    last_grant_d = pick;
                    gnt_wr_d     = pick ? m1_write : m0_write;
                    wr_started_d = 1'b0;
                    wr_cnt_d     = '0;
                    if (!pick) begin
                        starve_d = '0;
                    end else if (urgent_win) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                end
            end
            GNT0, GNT1: begin
                if (gnt_wr_q) begin
                    if (wr_accept) begin
                        if (!wr_started_q) begin
                            if (g_len == BC_W'(1)) begin
                                state_d = IDLE;
                            end else begin
                                wr_started_d = 1'b1;
                                wr_len_d     = g_len;
                                wr_cnt_d     = BC_W'(1);
                            end
                        end else if ((wr_cnt_q + BC_W'(1)) == wr_len_q) begin
                            state_d = IDLE;
                        end else begin
                            wr_cnt_d = wr_cnt_q + BC_W'(1);
                        end
                    end
                end else if (rd_accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            starve_q     <= '0;
            gnt_wr_q     <= 1'b0;
            wr_started_q <= 1'b0;
            wr_len_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            starve_q     <= starve_d;
            gnt_wr_q     <= gnt_wr_d;
            wr_started_q <= wr_started_d;
            wr_len_q     <= wr_len_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            head_beats_q <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q     <= next_ptr(rd_ptr_q);
                head_beats_q <= '0;
            end else if (rv_hit) begin
                head_beats_q <= head_beats_q + BC_W'(1);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            end
            if (avl_rdata_valid && fifo_empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    // Tracking storage needs no reset: entries are only read while the count is non-zero.
    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_owner_q[wr_ptr_q] <= sel1;
            fifo_len_q[wr_ptr_q]   <= g_len;
        end
    end

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Directed-plus-random bench for lpddr2_port_arbiter against a transaction-level model
// (grant order, beat counts and a queue of outstanding read owners).
module tb_lpddr2_port_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;
    localparam int BC_W   = 3;

    logic              iCLK = 1'b0;
    logic              iRST_n;
    logic              local_init_done, m1_urgent;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic [BC_W-1:0]   m0_burstcount, m1_burstcount;
    logic              m0_waitrequest_n, m1_waitrequest_n;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              avl_ready, avl_rdata_valid;
    logic [DATA_W-1:0] avl_rdata, avl_wdata;
    logic [ADDR_W-1:0] avl_addr;
    logic [BC_W-1:0]   avl_size;
    logic              avl_read_req, avl_write_req, avl_burstbegin, err_orphan;

    int nvec = 0;
    int nerr = 0;
    int wr_beats = 0;

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) begin
        if (avl_write_req && avl_ready) wr_beats <= wr_beats + 1;
    end

    lpddr2_port_arbiter dut (
        .iCLK             (iCLK),
        .iRST_n           (iRST_n),
        .local_init_done  (local_init_done),
        .m1_urgent        (m1_urgent),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_address       (m0_address),
        .m0_writedata     (m0_writedata),
        .m0_burstcount    (m0_burstcount),
        .m0_waitrequest_n (m0_waitrequest_n),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_address       (m1_address),
        .m1_writedata     (m1_writedata),
        .m1_burstcount    (m1_burstcount),
        .m1_waitrequest_n (m1_waitrequest_n),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .avl_ready        (avl_ready),
        .avl_rdata        (avl_rdata),
        .avl_rdata_valid  (avl_rdata_valid),
        .avl_addr         (avl_addr),
        .avl_wdata        (avl_wdata),
        .avl_size         (avl_size),
        .avl_read_req     (avl_read_req),
        .avl_write_req    (avl_write_req),
        .avl_burstbegin   (avl_burstbegin),
        .err_orphan       (err_orphan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    function automatic int eff(input int bc);
        return (bc == 0) ? 1 : bc;
    endfunction

    task automatic idle_inputs();
        local_init_done = 1'b1;
        m1_urgent       = 1'b0;
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_burstcount = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_burstcount = '0;
        avl_ready       = 1'b0;
        avl_rdata_valid = 1'b0;
        avl_rdata       = '0;
    endtask

    task automatic drive_m(input int m, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input int bc);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
            m0_burstcount = BC_W'(bc);
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
            m1_burstcount = BC_W'(bc);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        iRST_n = 1'b0;
        #1;
        @(negedge iCLK);
        iRST_n = 1'b1;
        step();
    endtask

    // One write burst from master m; stall_beat/drop_beat index beats from 0, -1 disables.
    task automatic run_write(input int m, input int bc, input int stall_beat, input int stall_cyc,
                             input int drop_beat);
        int len, beat, stalled, dropped, start;
        logic [DATA_W-1:0] data [4];
        logic [ADDR_W-1:0] addr;
        logic rdy, drop;
        len = eff(bc);
        for (int i = 0; i < 4; i++) data[i] = $urandom;
        addr = ADDR_W'($urandom);
        beat = 0; stalled = 0; dropped = 0;
        drive_m(m, 1'b0, 1'b1, addr, data[0], bc);
        avl_ready = 1'b1;
        step();
        start = wr_beats;
        for (int c = 0; c < 40 && beat < len; c++) begin
            drop = (beat == drop_beat) && (dropped < 2);
            rdy  = drop || !((beat == stall_beat) && (stalled < stall_cyc));
            drive_m(m, 1'b0, !drop, addr, data[beat], bc);
            avl_ready = rdy;
            #1;
            chk("wr_req", avl_write_req, !drop);
            chk("wr_burstbegin", avl_burstbegin, (beat == 0) && !drop);
            if (!drop) chk("wr_data", avl_wdata, data[beat]);
            chk("wr_size", avl_size, len);
            chk("wr_addr", avl_addr, addr);
            chk("wr_wrn_owner", (m == 0) ? m0_waitrequest_n : m1_waitrequest_n, rdy);
            chk("wr_wrn_other", (m == 0) ? m1_waitrequest_n : m0_waitrequest_n, 1'b0);
            if (drop) dropped++;
            else if (!rdy) stalled++;
            else beat++;
            step();
        end
        drive_m(m, 1'b0, 1'b0, addr, '0, bc);
        #1;
        chk("wr_done_beats", beat, len);
        chk("wr_beat_count", wr_beats - start, len);
        chk("wr_idle_req", avl_write_req, 1'b0);
        chk("wr_idle_wrn", (m == 0) ? m0_waitrequest_n : m1_waitrequest_n, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [ADDR_W-1:0] ra [2];
        int rbc [2];
        int q_own [$];
        int q_beats [$];
        int own, run, len;
        logic rdy, v;
        logic [DATA_W-1:0] d, d0, d1;

        // Reset state with requests and stray read data pending.
        iRST_n = 1'b1;
        idle_inputs();
        m0_read = 1'b1; m1_write = 1'b1; avl_rdata_valid = 1'b1; avl_ready = 1'b1;
        #2 iRST_n = 1'b0;
        step();
        chk("rst_read_req", avl_read_req, 1'b0);
        chk("rst_write_req", avl_write_req, 1'b0);
        chk("rst_burstbegin", avl_burstbegin, 1'b0);
        chk("rst_wrn0", m0_waitrequest_n, 1'b0);
        chk("rst_wrn1", m1_waitrequest_n, 1'b0);
        chk("rst_rdv0", m0_readdatavalid, 1'b0);
        chk("rst_rdv1", m1_readdatavalid, 1'b0);
        chk("rst_orphan", err_orphan, 1'b0);
        idle_inputs();
        @(negedge iCLK);
        iRST_n = 1'b1;
        step();

        // Write bursts: stall on beat 2, a mid-burst drop, and burstcount 0.
        run_write(0, 4, 1, 2, -1);
        do_reset();
        len = $urandom_range(2, 4);
        run_write(1, len, $urandom_range(0, len - 1), $urandom_range(0, 2), $urandom_range(1, len - 1));
        do_reset();
        run_write(0, 0, 0, 1, -1);

        // Alternating reads with random stalls and burst lengths, then in-order return.
        do_reset();
        for (int m = 0; m < 2; m++) begin
            ra[m]  = ADDR_W'($urandom);
            rbc[m] = $urandom_range(0, 4);
            drive_m(m, 1'b1, 1'b0, ra[m], '0, rbc[m]);
        end
        own = 0;
        for (int g = 0; g < 6; g++) begin
            step();
            for (int c = 0; c < 8; c++) begin
                rdy = (c == 7) || ($urandom_range(0, 2) != 0);
                avl_ready = rdy;
                #1;
                chk("rd_req", avl_read_req, 1'b1);
                chk("rd_burstbegin", avl_burstbegin, 1'b1);
                chk("rd_addr", avl_addr, ra[own]);
                chk("rd_size", avl_size, eff(rbc[own]));
                chk("rd_wrn0", m0_waitrequest_n, (own == 0) && rdy);
                chk("rd_wrn1", m1_waitrequest_n, (own == 1) && rdy);
                if (rdy) break;
                step();
            end
            q_own.push_back(own);
            q_beats.push_back(eff(rbc[own]));
            step();
            ra[own]  = ADDR_W'($urandom);
            rbc[own] = $urandom_range(0, 4);
            drive_m(own, g < 5, 1'b0, ra[own], '0, rbc[own]);
            if (g == 5) drive_m(1 - own, 1'b0, 1'b0, '0, '0, 0);
            avl_ready = 1'b0;
            #1;
            chk("rd_bubble", avl_read_req, 1'b0);
            own = 1 - own;
        end
        for (int c = 0; c < 200 && q_own.size() > 0; c++) begin
            step();
            v = ($urandom_range(0, 3) != 0);
            d = $urandom;
            avl_rdata_valid = v;
            avl_rdata = d;
            #1;
            chk("ret_rdv0", m0_readdatavalid, v && (q_own[0] == 0));
            chk("ret_rdv1", m1_readdatavalid, v && (q_own[0] == 1));
            if (v) begin
                chk("ret_data", (q_own[0] == 0) ? m0_readdata : m1_readdata, d);
                q_beats[0] = q_beats[0] - 1;
                if (q_beats[0] == 0) begin
                    void'(q_own.pop_front());
                    void'(q_beats.pop_front());
                end
            end
        end
        step();
        avl_rdata_valid = 1'b0;
        chk("ret_drained", q_own.size(), 0);
        step();
        chk("ret_no_orphan", err_orphan, 1'b0);

        // Urgent master 1 against continuous master-0 writes: runs of 16 then one to master 0.
        do_reset();
        d0 = $urandom; d1 = $urandom;
        m1_urgent = 1'b1;
        drive_m(0, 1'b0, 1'b1, ADDR_W'($urandom), d0, 1);
        drive_m(1, 1'b0, 1'b1, ADDR_W'($urandom), d1, 1);
        avl_ready = 1'b1;
        run = 0;
        for (int g = 0; g < 34; g++) begin
            step();
            chk("st_wrn1", m1_waitrequest_n, run < 16);
            chk("st_wrn0", m0_waitrequest_n, run >= 16);
            chk("st_wdata", avl_wdata, (run < 16) ? d1 : d0);
            run = (run < 16) ? run + 1 : 0;
            step();
        end

        // Tracking FIFO full: ninth read stalls, master 0 still served, two beats release it.
        do_reset();
        drive_m(1, 1'b1, 1'b0, ADDR_W'($urandom), '0, 2);
        avl_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("ff_read", avl_read_req, 1'b1);
            chk("ff_wrn1", m1_waitrequest_n, 1'b1);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ff_stall_req", avl_read_req, 1'b0);
            chk("ff_stall_wrn1", m1_waitrequest_n, 1'b0);
        end
        d = $urandom;
        drive_m(0, 1'b0, 1'b1, ADDR_W'($urandom), d, 1);
        step();
        chk("ff_m0_write", avl_write_req, 1'b1);
        chk("ff_m0_wrn", m0_waitrequest_n, 1'b1);
        chk("ff_m1_wrn", m1_waitrequest_n, 1'b0);
        step();
        drive_m(0, 1'b0, 1'b0, '0, '0, 0);
        for (int k = 0; k < 2; k++) begin
            avl_rdata_valid = 1'b1;
            avl_rdata = $urandom;
            #1;
            chk("ff_rdv1", m1_readdatavalid, 1'b1);
            chk("ff_rdv0", m0_readdatavalid, 1'b0);
            step();
        end
        avl_rdata_valid = 1'b0;
        #1;
        chk("ff_preop_full", avl_read_req, 1'b0);
        step();
        chk("ff_resume_req", avl_read_req, 1'b1);
        chk("ff_resume_wrn1", m1_waitrequest_n, 1'b1);

        // Reset with a command in flight and reads outstanding, then an orphan beat.
        iRST_n = 1'b0;
        #1;
        chk("rst_inflight_req", avl_read_req, 1'b0);
        chk("rst_inflight_wrn1", m1_waitrequest_n, 1'b0);
        idle_inputs();
        @(negedge iCLK);
        iRST_n = 1'b1;
        step();
        avl_rdata_valid = 1'b1;
        avl_rdata = $urandom;
        #1;
        chk("orphan_rdv0", m0_readdatavalid, 1'b0);
        chk("orphan_rdv1", m1_readdatavalid, 1'b0);
        step();
        avl_rdata_valid = 1'b0;
        chk("orphan_set", err_orphan, 1'b1);
        step();
        step();
        chk("orphan_sticky", err_orphan, 1'b1);
        iRST_n = 1'b0;
        #1;
        chk("orphan_cleared", err_orphan, 1'b0);
        @(negedge iCLK);
        iRST_n = 1'b1;
        step();

        // No grant while the controller is still initialising.
        do_reset();
        local_init_done = 1'b0;
        drive_m(0, 1'b1, 1'b0, ADDR_W'($urandom), '0, 1);
        drive_m(1, 1'b0, 1'b1, ADDR_W'($urandom), $urandom, 1);
        avl_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("init_rd", avl_read_req, 1'b0);
            chk("init_wr", avl_write_req, 1'b0);
            chk("init_bb", avl_burstbegin, 1'b0);
        end
        local_init_done = 1'b1;
        step();
        chk("init_first_rd", avl_read_req, 1'b1);
        chk("init_first_wrn0", m0_waitrequest_n, 1'b1);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
